stack_unit: RTL and testbench

- Parametrised hardware stack for the SAP-2 datapath, backing CALL/RET and PUSH/POP.
- Keeps a down-counting stack pointer and a private byte-wide stack RAM.
- Moves multi-byte words one byte per cycle, through a request/busy/done handshake driven by the control unit.
- Generalises the bare SP load/inr/dcr control lines into one unit with word width, depth, full/empty detection and sticky error flags.

---
 rtl/stack_unit_pkg.sv | 31 +++
 rtl/stack_unit_ram.sv | 32 +++
 rtl/stack_unit.sv | 191 +++++++++++++++++++
 tb/tb_stack_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_unit_pkg.sv
// stack_unit_pkg: shared types and helpers for the SAP-2 hardware stack.
//   state_t : transfer FSM states (IDLE / PUSH / POP), 2-bit encoding
//   clog2   : ceiling log2, usable in parameter expressions
//   sp_max  : stack size in bytes for a given depth/bytes-per-word
package stack_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PUSH = 2'd1,
    ST_POP  = 2'd2
  } state_t;

  localparam int unsigned DEF_BUS_W = 8;
  localparam int unsigned DEF_BYTES = 2;
  localparam int unsigned DEF_DEPTH = 16;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned sp_max(input int unsigned depth,
                                         input int unsigned bytes);
    return depth * bytes;
  endfunction

endpackage

// File: rtl/stack_unit_ram.sv
// stack_ram: private byte-wide stack storage.
//   clk     : write clock
//   i_we    : write enable
//   i_waddr : write byte address
//   i_wdata : write byte
//   i_raddr : read byte address
//   o_rdata : read byte (asynchronous)
// Contents are not reset.
module stack_ram
  import stack_unit_pkg::*;
#(
  parameter  int unsigned BUS_W = DEF_BUS_W,
  parameter  int unsigned WORDS = 32,
  localparam int unsigned AW    = (clog2(WORDS) > 0) ? clog2(WORDS) : 1
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [BUS_W-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [BUS_W-1:0] o_rdata
);

  logic [BUS_W-1:0] r_mem [WORDS];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stack_unit.sv
// stack_unit: parametrised hardware stack backing CALL/RET and PUSH/POP.
// Down-counting byte stack pointer; words move one byte per cycle.
//   clk, rst  : clock, asynchronous active-high reset
//   push_req  : start push of push_data (idle only)
//   push_data : word to push, latched on acceptance
//   pop_req   : start pop (idle only)
//   pop_data  : last popped word, registered
//   sp_load   : load sp from sp_in, clamped to SP_MAX (idle only)
//   sp_in     : new stack pointer value
//   err_clr   : clear both sticky error flags
//   sp        : current stack pointer (byte address of top)
//   busy      : transfer in progress
//   done      : one-cycle completion pulse
//   full      : fewer than BYTES bytes free
//   empty     : fewer than BYTES bytes stored
//   err_ovf   : sticky, push rejected while full
//   err_unf   : sticky, pop rejected while empty
module stack_unit
  import stack_unit_pkg::*;
#(
  parameter  int unsigned BUS_W  = DEF_BUS_W,
  parameter  int unsigned BYTES  = DEF_BYTES,
  parameter  int unsigned DEPTH  = DEF_DEPTH,
  localparam int unsigned WORD_W = BUS_W * BYTES,
  localparam int unsigned SP_MAX = sp_max(DEPTH, BYTES),
  localparam int unsigned SP_W   = clog2(SP_MAX) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_req,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop_req,
  output logic [WORD_W-1:0] pop_data,
  input  logic              sp_load,
  input  logic [SP_W-1:0]   sp_in,
  input  logic              err_clr,
  output logic [SP_W-1:0]   sp,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              empty,
  output logic              err_ovf,
  output logic              err_unf
);

  localparam int unsigned AW = (SP_W > 1) ? SP_W - 1 : 1;
  localparam int unsigned IW = (clog2(BYTES) > 0) ? clog2(BYTES) : 1;

  localparam logic [SP_W-1:0] C_SP_MAX = SP_W'(SP_MAX);
  localparam logic [SP_W-1:0] C_BYTES  = SP_W'(BYTES);
  localparam logic [SP_W-1:0] C_ONE    = SP_W'(1);
  localparam logic [IW-1:0]   C_LAST   = IW'(BYTES - 1);

  state_t            r_state, w_state_nxt;
  logic [SP_W-1:0]   r_sp, w_sp_nxt, w_level, w_sp_clamp;
  logic [WORD_W-1:0] r_word, w_word_nxt;
  logic [WORD_W-1:0] r_pop_data, w_pop_data_nxt, w_asm;
  logic [IW-1:0]     r_idx, w_idx_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err_ovf, w_err_ovf_nxt, w_ovf_evt;
  logic              r_err_unf, w_err_unf_nxt, w_unf_evt;
  logic              w_full, w_empty, w_last;

  logic              w_ram_we;
  logic [AW-1:0]     w_ram_waddr, w_ram_raddr;
  logic [BUS_W-1:0]  w_ram_wdata, w_ram_rdata;

  stack_ram #(
    .BUS_W (BUS_W),
    .WORDS (SP_MAX)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_ram_rdata)
  );

  // sp never exceeds SP_MAX, so level cannot underflow.
  assign w_level    = C_SP_MAX - r_sp;
  assign w_full     = (r_sp < C_BYTES);
  assign w_empty    = (w_level < C_BYTES);
  assign w_last     = (r_idx == C_LAST);
  assign w_sp_clamp = (sp_in > C_SP_MAX) ? C_SP_MAX : sp_in;

  // Push sends the high byte first from the top of the shift register;
  // pop shifts each new byte in from the top, so the first (low) byte
  // read ends up in the least significant position.
  assign w_ram_waddr = AW'(r_sp - C_ONE);
  assign w_ram_raddr = AW'(r_sp);
  assign w_ram_wdata = r_word[WORD_W-1 -: BUS_W];
  assign w_asm       = (r_word >> BUS_W) | (WORD_W'(w_ram_rdata) << (WORD_W - BUS_W));

  always_comb begin
    w_state_nxt    = r_state;
    w_sp_nxt       = r_sp;
    w_word_nxt     = r_word;
    w_idx_nxt      = r_idx;
    w_pop_data_nxt = r_pop_data;
    w_done_nxt     = 1'b0;
    w_ram_we       = 1'b0;
    w_ovf_evt      = 1'b0;
    w_unf_evt      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (sp_load) begin
          w_sp_nxt = w_sp_clamp;
        end else if (push_req) begin
          if (w_full) begin
            w_ovf_evt = 1'b1;
          end else begin
            w_word_nxt  = push_data;
            w_idx_nxt   = '0;
            w_state_nxt = ST_PUSH;
          end
        end else if (pop_req) begin
          if (w_empty) begin
            w_unf_evt = 1'b1;
          end else begin
            w_idx_nxt   = '0;
            w_state_nxt = ST_POP;
          end
        end
      end

      ST_PUSH: begin
        w_ram_we   = 1'b1;
        w_sp_nxt   = r_sp - C_ONE;
        w_word_nxt = r_word << BUS_W;
        w_idx_nxt  = r_idx + IW'(1);
        if (w_last) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end

      ST_POP: begin
        w_sp_nxt   = r_sp + C_ONE;
        w_word_nxt = w_asm;
        w_idx_nxt  = r_idx + IW'(1);
        if (w_last) begin
          w_pop_data_nxt = w_asm;
          w_state_nxt    = ST_IDLE;
          w_done_nxt     = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // A new error event outranks a simultaneous clear.
    w_err_ovf_nxt = w_ovf_evt | (r_err_ovf & ~err_clr);
    w_err_unf_nxt = w_unf_evt | (r_err_unf & ~err_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sp       <= C_SP_MAX;
      r_word     <= '0;
      r_idx      <= '0;
      r_pop_data <= '0;
      r_done     <= 1'b0;
      r_err_ovf  <= 1'b0;
      r_err_unf  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sp       <= w_sp_nxt;
      r_word     <= w_word_nxt;
      r_idx      <= w_idx_nxt;
      r_pop_data <= w_pop_data_nxt;
      r_done     <= w_done_nxt;
      r_err_ovf  <= w_err_ovf_nxt;
      r_err_unf  <= w_err_unf_nxt;
    end
  end

  assign sp       = r_sp;
  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign full     = w_full;
  assign empty    = w_empty;
  assign pop_data = r_pop_data;
  assign err_ovf  = r_err_ovf;
  assign err_unf  = r_err_unf;

endmodule

// File: tb/tb_stack_unit.sv
module tb_stack_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_req, pop_req, sp_load, err_clr;
  logic [15:0] push_data, pop_data;
  logic [3:0]  sp_in, sp;
  logic        busy, done, full, empty, err_ovf, err_unf;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: byte-addressed memory image plus stack pointer.
  int          m_sp;
  logic [15:0] m_pd;
  bit          m_pd_known;
  bit          m_ovf, m_unf;
  logic [7:0]  m_mem [8];
  bit          m_val [8];

  stack_unit #(
    .BUS_W (8),
    .BYTES (2),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .push_req  (push_req),
    .push_data (push_data),
    .pop_req   (pop_req),
    .pop_data  (pop_data),
    .sp_load   (sp_load),
    .sp_in     (sp_in),
    .err_clr   (err_clr),
    .sp        (sp),
    .busy      (busy),
    .done      (done),
    .full      (full),
    .empty     (empty),
    .err_ovf   (err_ovf),
    .err_unf   (err_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    push_req = 1'b0;
    pop_req  = 1'b0;
    sp_load  = 1'b0;
    err_clr  = 1'b0;
  endtask

  // Arbitrary requests while busy; all must be ignored.
  task automatic junk();
    push_req  = 1'($urandom_range(0, 1));
    pop_req   = 1'($urandom_range(0, 1));
    sp_load   = 1'($urandom_range(0, 1));
    sp_in     = 4'($urandom);
    push_data = 16'($urandom);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sp"},    sp,      m_sp);
    chk({tag, "_full"},  full,    (m_sp < 2));
    chk({tag, "_empty"}, empty,   ((8 - m_sp) < 2));
    chk({tag, "_busy"},  busy,    1'b0);
    chk({tag, "_ovf"},   err_ovf, m_ovf);
    chk({tag, "_unf"},   err_unf, m_unf);
    if (m_pd_known) chk({tag, "_pd"}, pop_data, m_pd);
  endtask

  task automatic do_push(input logic [15:0] w, input bit with_pop, input bit clr);
    bit acc;
    acc       = (m_sp >= 2);
    push_req  = 1'b1;
    pop_req   = with_pop;
    push_data = w;
    err_clr   = clr;
    tick();
    clear_in();
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (acc) begin
      chk("push_busy1", busy, 1'b1);
      chk("push_done1", done, 1'b0);
      junk();
      tick();
      chk("push_busy2", busy, 1'b1);
      chk("push_done2", done, 1'b0);
      junk();
      tick();
      clear_in();
      m_mem[m_sp-1] = w[15:8];
      m_mem[m_sp-2] = w[7:0];
      m_val[m_sp-1] = 1'b1;
      m_val[m_sp-2] = 1'b1;
      m_sp = m_sp - 2;
      chk("push_done", done, 1'b1);
      chk_idle("push");
      tick();
      chk("push_done_low", done, 1'b0);
    end else begin
      m_ovf = 1'b1;
      chk("push_rej_done", done, 1'b0);
      chk_idle("push_rej");
    end
  endtask

  task automatic do_pop(input bit clr);
    bit acc;
    acc     = ((8 - m_sp) >= 2);
    pop_req = 1'b1;
    err_clr = clr;
    tick();
    clear_in();
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (acc) begin
      chk("pop_busy1", busy, 1'b1);
      chk("pop_done1", done, 1'b0);
      junk();
      tick();
      chk("pop_busy2", busy, 1'b1);
      chk("pop_done2", done, 1'b0);
      junk();
      tick();
      clear_in();
      m_pd_known = m_val[m_sp] && m_val[m_sp+1];
      m_pd       = {m_mem[m_sp+1], m_mem[m_sp]};
      m_sp       = m_sp + 2;
      chk("pop_done", done, 1'b1);
      chk_idle("pop");
      tick();
      chk("pop_done_low", done, 1'b0);
    end else begin
      m_unf = 1'b1;
      chk("pop_rej_done", done, 1'b0);
      chk_idle("pop_rej");
    end
  endtask

  task automatic do_load(input int v, input bit with_push);
    sp_load   = 1'b1;
    sp_in     = 4'(v);
    push_req  = with_push;
    pop_req   = 1'($urandom_range(0, 1));
    push_data = 16'($urandom);
    tick();
    clear_in();
    m_sp = (v > 8) ? 8 : v;
    chk("load_done", done, 1'b0);
    chk_idle("load");
  endtask

  task automatic do_clr();
    err_clr = 1'b1;
    tick();
    clear_in();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    chk_idle("clr");
  endtask

  initial begin
    int r;
    rst       = 1'b1;
    push_data = '0;
    sp_in     = '0;
    clear_in();
    m_sp       = 8;
    m_pd       = '0;
    m_pd_known = 1'b1;
    m_ovf      = 1'b0;
    m_unf      = 1'b0;
    for (int i = 0; i < 8; i++) m_val[i] = 1'b0;

    // Reset state
    #12;
    chk("rst_done", done, 1'b0);
    chk_idle("rst");
    rst = 1'b0;

    // Single push/pop round trip
    do_push(16'h1234, 1'b0, 1'b0);
    do_pop(1'b0);
    chk("rt_pd", pop_data, 16'h1234);

    // Fill to capacity, overflow, then LIFO drain
    for (int i = 1; i <= 4; i++) do_push(16'hA000 + 16'(i), 1'b0, 1'b0);
    chk("fill_full", full, 1'b1);
    do_push(16'hA005, 1'b0, 1'b0);
    for (int i = 4; i >= 1; i--) begin
      do_pop(1'b0);
      chk("drain_pd", pop_data, 16'hA000 + 16'(i));
    end

    // Underflow with simultaneous clear: error event wins, ovf clears
    do_pop(1'b1);
    do_clr();

    // push has priority over pop; sp_load has priority over push
    do_push(16'h5555, 1'b1, 1'b0);
    do_pop(1'b0);
    chk("prio_pd", pop_data, 16'h5555);
    do_load(5, 1'b1);
    do_push(16'($urandom), 1'b0, 1'b0);
    do_pop(1'b0);
    do_load(15, 1'b0);

    // Reset one cycle into a push
    push_req  = 1'b1;
    push_data = 16'hBEEF;
    tick();
    clear_in();
    chk("mid_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    m_sp       = 8;
    m_ovf      = 1'b0;
    m_unf      = 1'b0;
    m_pd       = '0;
    m_pd_known = 1'b1;
    chk("mid_rst_sp", sp, 4'd8);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    #1 rst = 1'b0;
    tick();
    chk("post_rst_done", done, 1'b0);
    chk_idle("post_rst");
    do_pop(1'b0);

    // Randomized operation mix
    for (int n = 0; n < 120; n++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 3)
        do_push(16'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      else if (r <= 6)
        do_pop($urandom_range(0, 3) == 0);
      else if (r == 7)
        do_load(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      else if (r == 8)
        do_clr();
      else begin
        tick();
        chk("idle_done", done, 1'b0);
        chk_idle("idle");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
